// File: rtl/uart_pkg.sv
// Definitions shared by both directions of the board-interface UART link:
// command-byte layout, defaults and the transmit FSM state type.
package uart_pkg;

    localparam int unsigned RIGHT_B  = 0;
    localparam int unsigned LEFT_B   = 1;
    localparam int unsigned UP_B     = 2;
    localparam int unsigned DOWN_B   = 3;
    localparam int unsigned TRIG_B   = 4;
    localparam int unsigned NUM_CTRL = 5;

    localparam logic [2:0]  HEADER_DEF       = 3'b101;
    localparam int unsigned CLKS_PER_BIT_DEF = 217;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

    function automatic logic [7:0] encode_cmd(input logic [2:0] header,
                                              input logic [NUM_CTRL-1:0] vec);
        return {header, vec};
    endfunction

endpackage

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: loads a byte on i_start and shifts it out LSB first
// between a start and a stop bit, each bit lasting CLKS_PER_BIT clocks.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam int unsigned   BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = StStart;
                    shift_d = i_data;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            StStart: begin
                if (baud_end) begin
                    state_d = StData;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_end) begin
                    state_d = StIdle;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from next-state so the TX pin never glitches.
        tx_d   = (state_d == StStart) ? 1'b0 : (state_d == StData) ? shift_d[0] : 1'b1;
        busy_d = (state_d != StIdle);
        done_d = (state_d == StStop) && (baud_d == BAUD_LAST);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_tx   = tx_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: rtl/uart_encode_tx.sv
// Samples the five control lines, encodes them into a command byte and sends
// it over UART on every change of the synchronised vector and on heartbeat.
module uart_encode_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = CLKS_PER_BIT_DEF,
    parameter int unsigned HEARTBEAT_CLKS = 2500000,
    parameter logic [2:0]  HEADER         = HEADER_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_right,
    input  logic i_left,
    input  logic i_up,
    input  logic i_down,
    input  logic i_trigger,
    output logic o_tx,
    output logic o_busy,
    output logic o_done
);

    localparam int unsigned    HBW     = (HEARTBEAT_CLKS > 1) ? $clog2(HEARTBEAT_CLKS) : 1;
    localparam logic [HBW-1:0] HB_LAST = HBW'(HEARTBEAT_CLKS - 1);

    logic [NUM_CTRL-1:0] raw_vec, sync1_q, sync2_q, cur_vec;
    logic [NUM_CTRL-1:0] last_q, last_d;
    logic                pending_q, pending_d;
    logic [HBW-1:0]      hb_q, hb_d;
    logic                changed, hb_hit, start, tx_busy;

    always_comb begin
        raw_vec         = '0;
        raw_vec[RIGHT_B] = i_right;
        raw_vec[LEFT_B]  = i_left;
        raw_vec[UP_B]    = i_up;
        raw_vec[DOWN_B]  = i_down;
        raw_vec[TRIG_B]  = i_trigger;
    end

    assign cur_vec = sync2_q;
    assign changed = (cur_vec != last_q);
    assign hb_hit  = (HEARTBEAT_CLKS != 0) && (hb_q == HB_LAST);
    // An idle transmitter starts in the same cycle the request appears.
    assign start   = !tx_busy && (pending_q || changed || hb_hit);

    always_comb begin
        last_d    = last_q;
        pending_d = pending_q;
        hb_d      = hb_q;
        if (start) begin
            last_d    = cur_vec;
            pending_d = 1'b0;
            hb_d      = '0;
        end else begin
            if (changed || hb_hit) begin
                pending_d = 1'b1;
            end
            if (HEARTBEAT_CLKS != 0) begin
                hb_d = hb_hit ? '0 : hb_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            last_q    <= '0;
            pending_q <= 1'b0;
            hb_q      <= '0;
        end else begin
            sync1_q   <= raw_vec;
            sync2_q   <= sync1_q;
            last_q    <= last_d;
            pending_q <= pending_d;
            hb_q      <= hb_d;
        end
    end

    uart_transmitter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_start(start),
        .i_data (encode_cmd(HEADER, cur_vec)),
        .o_tx   (o_tx),
        .o_busy (tx_busy),
        .o_done (o_done)
    );

    assign o_busy = tx_busy;

endmodule

// File: tb/tb_uart_encode_tx.sv
// Bench for uart_encode_tx: a serial-line monitor decodes frames from two
// instances (no heartbeat / heartbeat 200) and scores them against expectations.
module tb_uart_encode_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
    localparam int HB    = 200;

    typedef struct {
        int         dut;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        int         dut;
        logic [7:0] data;
        int         start;
    } frame_t;

    typedef struct {
        logic [4:0] vec;
        logic [7:0] byte_exp;
    } vec_t;

    logic clk, rst0_n, rst1_n;
    logic right, left, up, down, trig;
    logic tx0, busy0, done0, tx1, busy1, done1;

    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;
    int     idle_err[2];
    int     nfr[2];
    exp_t   exp_q[$];
    frame_t fr_q[$];

    uart_encode_tx #(
        .CLKS_PER_BIT  (CPB),
        .HEARTBEAT_CLKS(0),
        .HEADER        (3'b101)
    ) dut0 (
        .i_clk    (clk),
        .i_rst_n  (rst0_n),
        .i_right  (right),
        .i_left   (left),
        .i_up     (up),
        .i_down   (down),
        .i_trigger(trig),
        .o_tx     (tx0),
        .o_busy   (busy0),
        .o_done   (done0)
    );

    uart_encode_tx #(
        .CLKS_PER_BIT  (CPB),
        .HEARTBEAT_CLKS(HB),
        .HEADER        (3'b101)
    ) dut1 (
        .i_clk    (clk),
        .i_rst_n  (rst1_n),
        .i_right  (right),
        .i_left   (left),
        .i_up     (up),
        .i_down   (down),
        .i_trigger(trig),
        .o_tx     (tx1),
        .o_busy   (busy1),
        .o_done   (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic rstn(input int d);
        return (d == 0) ? rst0_n : rst1_n;
    endfunction
    function automatic logic txs(input int d);
        return (d == 0) ? tx0 : tx1;
    endfunction
    function automatic logic busys(input int d);
        return (d == 0) ? busy0 : busy1;
    endfunction
    function automatic logic dones(input int d);
        return (d == 0) ? done0 : done1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    task automatic set_in(input logic [4:0] vec);
        {trig, down, up, left, right} = vec;
    endtask

    function automatic int start_of(input int d, input int idx);
        int n   = 0;
        int res = -1;
        foreach (fr_q[i]) begin
            if (fr_q[i].dut == d) begin
                if (n == idx) res = fr_q[i].start;
                n++;
            end
        end
        return res;
    endfunction

    // Decodes one frame per start bit; checks bit widths, busy and done placement.
    task automatic monitor(input int d);
        frame_t     fr;
        logic [7:0] data;
        logic       shape_ok, aborted;
        int         bi, hit;
        forever begin
            @(negedge clk);
            if (rstn(d) && txs(d) !== 1'b0) begin
                if (busys(d) !== 1'b0 || dones(d) !== 1'b0) idle_err[d]++;
            end else if (rstn(d)) begin
                fr.dut   = d;
                fr.start = cyc;
                data     = '0;
                shape_ok = 1'b1;
                aborted  = 1'b0;
                for (int k = 0; k < FRAME; k++) begin
                    if (k > 0) @(negedge clk);
                    if (!rstn(d)) begin
                        aborted = 1'b1;
                        break;
                    end
                    bi = k / CPB;
                    if (bi == 0) begin
                        if (txs(d) !== 1'b0) shape_ok = 1'b0;
                    end else if (bi == 9) begin
                        if (txs(d) !== 1'b1) shape_ok = 1'b0;
                    end else if (k % CPB == 0) begin
                        data[bi-1] = txs(d);
                    end else if (txs(d) !== data[bi-1]) begin
                        shape_ok = 1'b0;
                    end
                    if (busys(d) !== 1'b1) shape_ok = 1'b0;
                    if (dones(d) !== (k == FRAME - 1)) shape_ok = 1'b0;
                end
                if (!aborted) begin
                    chk($sformatf("frame_shape_dut%0d_at%0d", d, fr.start), shape_ok, 1);
                    fr.data = data;
                    hit = -1;
                    foreach (exp_q[i]) if (hit < 0 && exp_q[i].dut == d) hit = i;
                    if (hit < 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_frame_dut%0d: got byte 0x%0h, none expected",
                                 d, data);
                    end else begin
                        chk($sformatf("frame_byte_dut%0d_at%0d", d, fr.start), data,
                            exp_q[hit].data);
                        exp_q.delete(hit);
                    end
                    fr_q.push_back(fr);
                    nfr[d]++;
                end
            end
        end
    endtask

    task automatic wait_frames(input int d, input int n, input int budget, input string name);
        int t = 0;
        while (nfr[d] < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk(name, nfr[d], n);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   base, base0, drv, t;

        tbl[0] = '{vec: 5'b00100, byte_exp: 8'hA4};
        tbl[1] = '{vec: 5'b00011, byte_exp: 8'hA3};
        tbl[2] = '{vec: 5'b10000, byte_exp: 8'hB0};
        tbl[3] = '{vec: 5'b11111, byte_exp: 8'hBF};
        tbl[4] = '{vec: 5'b01000, byte_exp: 8'hA8};
        tbl[5] = '{vec: 5'b00000, byte_exp: 8'hA0};

        rst0_n = 1'b0;
        rst1_n = 1'b0;
        set_in(5'b00000);
        fork
            monitor(0);
            monitor(1);
        join_none
        repeat (3) @(negedge clk);
        chk("reset_tx0", tx0, 1);
        chk("reset_busy0", busy0, 0);
        chk("reset_done0", done0, 0);
        chk("reset_tx1", tx1, 1);
        chk("reset_busy1", busy1, 0);
        rst0_n = 1'b1;

        // Quiet line with all inputs low.
        repeat (100) @(negedge clk);
        chk("quiet_frames", nfr[0], 0);
        chk("quiet_idle", idle_err[0], 0);
        chk("quiet_tx", tx0, 1);

        for (int i = 0; i < 6; i++) begin
            base = nfr[0];
            set_in(tbl[i].vec);
            drv = cyc;
            exp_q.push_back('{dut: 0, data: tbl[i].byte_exp});
            wait_frames(0, base + 1, 100, $sformatf("table%0d_frame", i));
            chk($sformatf("table%0d_latency", i), start_of(0, base) - drv, 3);
            repeat (5) @(negedge clk);
        end

        // Changes during a frame: intermediate value dropped, newest one sent after one gap cycle.
        base = nfr[0];
        set_in(5'b00100);
        exp_q.push_back('{dut: 0, data: 8'hA4});
        repeat (15) @(negedge clk);
        set_in(5'b00001);
        repeat (7) @(negedge clk);
        set_in(5'b10101);
        exp_q.push_back('{dut: 0, data: 8'hB5});
        wait_frames(0, base + 2, 200, "midframe_frames");
        chk("midframe_gap", start_of(0, base + 1) - start_of(0, base), FRAME + 1);
        repeat (200) @(negedge clk);
        chk("midframe_no_third", nfr[0], base + 2);

        // Trigger pulses and reverts inside a frame: one resend of the current value.
        base = nfr[0];
        set_in(5'b00000);
        exp_q.push_back('{dut: 0, data: 8'hA0});
        repeat (12) @(negedge clk);
        set_in(5'b10000);
        repeat (6) @(negedge clk);
        set_in(5'b00000);
        exp_q.push_back('{dut: 0, data: 8'hA0});
        wait_frames(0, base + 2, 200, "toggle_frames");
        chk("toggle_gap", start_of(0, base + 1) - start_of(0, base), FRAME + 1);
        repeat (150) @(negedge clk);
        chk("toggle_no_extra", nfr[0], base + 2);

        // Reset during a low data bit.
        set_in(5'b00100);
        exp_q.push_back('{dut: 0, data: 8'hA4});
        t = 0;
        while (tx0 !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rst_frame_started", tx0, 0);
        repeat (5) @(negedge clk);
        chk("rst_data_low", tx0, 0);
        chk("rst_busy_before", busy0, 1);
        #1 rst0_n = 1'b0;
        #1;
        chk("rst_tx_high", tx0, 1);
        chk("rst_busy_low", busy0, 0);
        for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].dut == 0) exp_q.delete(i);
        set_in(5'b01000);
        repeat (3) @(negedge clk);
        base = nfr[0];
        rst0_n = 1'b1;
        exp_q.push_back('{dut: 0, data: 8'hA8});
        wait_frames(0, base + 1, 100, "post_reset_frame");
        repeat (5) @(negedge clk);

        // Heartbeat instance with a static input.
        base0 = nfr[0];
        set_in(5'b00010);
        drv = cyc;
        rst1_n = 1'b1;
        exp_q.push_back('{dut: 0, data: 8'hA2});
        for (int i = 0; i < 4; i++) exp_q.push_back('{dut: 1, data: 8'hA2});
        wait_frames(1, 4, 1000, "hb_frames");
        chk("hb_first_latency", start_of(1, 0) - drv, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("hb_period%0d", i), start_of(1, i + 1) - start_of(1, i), HB);
        end
        chk("hb_dut0_single", nfr[0], base0 + 1);

        chk("exp_drained", exp_q.size(), 0);
        chk("idle_dut0", idle_err[0], 0);
        chk("idle_dut1", idle_err[1], 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
